rx_frame_rr_arbiter: RTL and testbench

Frame-granular round-robin arbiter that merges N_PORTS receive AXIS streams into one 64-bit AXIS stream. Each input carries CRC-filtered frames with 80-bit user sideband: len[79:64] and user[63:0]. Sits downstream of the per-port CRC filtering stage and feeds the shared RX parser. A granted port holds the output until its rlast, so frames never interleave. An oversize guard truncates runaway frames.

---
 rtl/rx_arb_pkg.sv | 19 +
 rtl/rr_priority_pick.sv | 39 +++
 rtl/rx_frame_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_rx_frame_rr_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_arb_pkg.sv
// Shared types and widths for the RX frame round-robin arbiter.
package rx_arb_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned USER_W = 80;
  localparam int unsigned KEEP_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDrop = 2'd2
  } arb_state_e;

  // Port-id width; a single-bit id is kept even for degenerate port counts.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first requester at or after ptr_i, wrapping modulo N_PORTS.
module rr_priority_pick
  import rx_arb_pkg::*;
#(
  parameter  int unsigned N_PORTS = 2,
  localparam int unsigned ID_W    = id_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               any_o,
  output logic [ID_W-1:0]    idx_o
);

  localparam logic [ID_W:0] NPorts = (ID_W + 1)'(N_PORTS);

  logic [N_PORTS-1:0] req_rot;
  logic [ID_W-1:0]    rot_idx;
  logic [ID_W:0]      idx_sum;

  // Rotate so the port at ptr_i lands on bit 0.
  assign req_rot = N_PORTS'({req_i, req_i} >> ptr_i);
  assign any_o   = |req_i;

  // Priority-encode the rotated vector: lowest set bit wins.
  always_comb begin
    rot_idx = '0;
    for (int k = int'(N_PORTS) - 1; k >= 0; k--) begin
      if (req_rot[k]) rot_idx = ID_W'(k);
    end
  end

  // Un-rotate back to an absolute port index.
  always_comb begin
    idx_sum = {1'b0, rot_idx} + {1'b0, ptr_i};
    if (idx_sum >= NPorts) idx_sum = idx_sum - NPorts;
    idx_o = idx_sum[ID_W-1:0];
  end

endmodule

// File: rtl/rx_frame_rr_arbiter.sv
// Frame-granular round-robin merge of N_PORTS RX AXIS streams into one stream.
// A grant is held until the frame's rlast; runaway frames are truncated.
module rx_frame_rr_arbiter
  import rx_arb_pkg::*;
#(
  parameter  int unsigned N_PORTS   = 2,
  parameter  int unsigned MAX_BEATS = 256,
  localparam int unsigned ID_W      = id_width(N_PORTS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_PORTS*DATA_W-1:0] s_axis_rdata,
  input  logic [N_PORTS*USER_W-1:0] s_axis_ruser,
  input  logic [N_PORTS*KEEP_W-1:0] s_axis_rkeep,
  input  logic [N_PORTS-1:0]        s_axis_rlast,
  input  logic [N_PORTS-1:0]        s_axis_rvalid,
  output logic [N_PORTS-1:0]        s_axis_rready,
  output logic [DATA_W-1:0]         m_axis_rdata,
  output logic [USER_W-1:0]         m_axis_ruser,
  output logic [KEEP_W-1:0]         m_axis_rkeep,
  output logic                      m_axis_rlast,
  output logic                      m_axis_rvalid,
  output logic [ID_W-1:0]           m_axis_rport,
  output logic                      o_trunc_err,
  output logic                      o_busy
);

  localparam int unsigned      CNT_W   = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MAX_BEATS - 1);

  arb_state_e        state_q;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]  beat_cnt_q;

  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic [DATA_W-1:0] sel_data;
  logic [USER_W-1:0] sel_user;
  logic [KEEP_W-1:0] sel_keep;
  logic              sel_last;
  logic              sel_valid;
  logic              active;
  logic              accept;
  logic [ID_W-1:0]   ptr_next;

  rr_priority_pick #(
    .N_PORTS(N_PORTS)
  ) u_pick (
    .req_i(s_axis_rvalid),
    .ptr_i(rr_ptr_q),
    .any_o(pick_any),
    .idx_o(pick_idx)
  );

  assign active   = (state_q == StSend) || (state_q == StDrop);
  assign accept   = active && sel_valid;
  assign ptr_next = (grant_q == ID_W'(N_PORTS - 1)) ? '0 : grant_q + ID_W'(1);
  assign o_busy   = (state_q != StIdle);

  // Mux the granted port's beat; ready is decoded from registered state only.
  always_comb begin
    sel_data      = '0;
    sel_user      = '0;
    sel_keep      = '0;
    sel_last      = 1'b0;
    sel_valid     = 1'b0;
    s_axis_rready = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (grant_q == ID_W'(p)) begin
        sel_data         = s_axis_rdata[p*DATA_W +: DATA_W];
        sel_user         = s_axis_ruser[p*USER_W +: USER_W];
        sel_keep         = s_axis_rkeep[p*KEEP_W +: KEEP_W];
        sel_last         = s_axis_rlast[p];
        sel_valid        = s_axis_rvalid[p];
        s_axis_rready[p] = active;
      end
    end
  end

  // Arbitration FSM, beat counter and registered output stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      m_axis_rdata  <= '0;
      m_axis_ruser  <= '0;
      m_axis_rkeep  <= '0;
      m_axis_rlast  <= 1'b0;
      m_axis_rvalid <= 1'b0;
      m_axis_rport  <= '0;
      o_trunc_err   <= 1'b0;
    end else begin
      // No beat by default; ruser and rport deliberately hold.
      m_axis_rdata  <= '0;
      m_axis_rkeep  <= '0;
      m_axis_rlast  <= 1'b0;
      m_axis_rvalid <= 1'b0;
      o_trunc_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            grant_q    <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= StSend;
          end
        end
        StSend: begin
          if (accept) begin
            beat_cnt_q    <= beat_cnt_q + CNT_W'(1);
            m_axis_rdata  <= sel_data;
            m_axis_ruser  <= sel_user;
            m_axis_rkeep  <= sel_keep;
            m_axis_rvalid <= 1'b1;
            m_axis_rport  <= grant_q;
            if (sel_last) begin
              m_axis_rlast <= 1'b1;
              rr_ptr_q     <= ptr_next;
              state_q      <= StIdle;
            end else if (beat_cnt_q == LastCnt) begin
              // Close the frame downstream and swallow the rest of it.
              m_axis_rlast <= 1'b1;
              o_trunc_err  <= 1'b1;
              state_q      <= StDrop;
            end
          end
        end
        StDrop: begin
          if (accept && sel_last) begin
            rr_ptr_q <= ptr_next;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_rr_arbiter.sv
// Bench for rx_frame_rr_arbiter: frame-queue sources, per-port expected-beat
// scoreboard and a round-robin grant checker driven from sampled requests.
module tb_rx_frame_rr_arbiter;
  import rx_arb_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned MB = 8;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic [NP*DATA_W-1:0] s_rdata;
  logic [NP*USER_W-1:0] s_ruser;
  logic [NP*KEEP_W-1:0] s_rkeep;
  logic [NP-1:0]        s_rlast;
  logic [NP-1:0]        s_rvalid;
  logic [NP-1:0]        s_rready;
  logic [DATA_W-1:0]    m_rdata;
  logic [USER_W-1:0]    m_ruser;
  logic [KEEP_W-1:0]    m_rkeep;
  logic                 m_rlast;
  logic                 m_rvalid;
  logic [0:0]           m_rport;
  logic                 o_trunc_err;
  logic                 o_busy;

  always #5 i_clk = ~i_clk;

  rx_frame_rr_arbiter #(
    .N_PORTS  (NP),
    .MAX_BEATS(MB)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .s_axis_rdata (s_rdata),
    .s_axis_ruser (s_ruser),
    .s_axis_rkeep (s_rkeep),
    .s_axis_rlast (s_rlast),
    .s_axis_rvalid(s_rvalid),
    .s_axis_rready(s_rready),
    .m_axis_rdata (m_rdata),
    .m_axis_ruser (m_ruser),
    .m_axis_rkeep (m_rkeep),
    .m_axis_rlast (m_rlast),
    .m_axis_rvalid(m_rvalid),
    .m_axis_rport (m_rport),
    .o_trunc_err  (o_trunc_err),
    .o_busy       (o_busy)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [79:0] user;
    logic [7:0]  keep;
    logic        last;
    logic        trunc;
  } beat_t;

  typedef struct {
    int port;
    int nbeats;
    int exp_beats;
    int exp_trunc;
  } vec_t;

  beat_t         src_q[NP][$];
  beat_t         exp_q[NP][$];
  int            gap[NP];
  int            out_ports[$];
  int            starts[$];
  logic [NP-1:0] hs, prev_ready, prev_valid;
  logic          in_frame, prev_out_last;
  int            cur_port, exp_ptr, n_out_beats, n_trunc;
  bit            rnd_gaps;
  int            n_tests = 0;
  int            n_fail = 0;

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endfunction

  // Round-robin rule: first requester scanning ptr, ptr+1, ... mod NP.
  function automatic int rr_winner(input logic [NP-1:0] v, input int ptr);
    for (int k = 0; k < NP; k++) begin
      if (v[(ptr + k) % NP]) return (ptr + k) % NP;
    end
    return -1;
  endfunction

  task automatic add_frame(input int p, input int n, input logic [63:0] base,
                           input logic [63:0] usr);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data  = base + 64'(i) * 64'h11;
      b.user  = {16'(n), usr};
      b.keep  = (i == n - 1) ? 8'h0f : 8'hff;
      b.last  = (i == n - 1);
      b.trunc = 1'b0;
      src_q[p].push_back(b);
      if (i < MB) begin
        if (i == MB - 1 && !b.last) begin
          b.last  = 1'b1;
          b.trunc = 1'b1;
        end
        exp_q[p].push_back(b);
      end
    end
  endtask

  task automatic drive();
    beat_t b;
    logic  v;
    for (int p = 0; p < NP; p++) begin
      b = '0;
      v = 1'b0;
      if (src_q[p].size() > 0 && gap[p] == 0) begin
        b = src_q[p][0];
        v = 1'b1;
      end
      s_rdata[p*64 +: 64] = b.data;
      s_ruser[p*80 +: 80] = b.user;
      s_rkeep[p*8 +: 8]   = b.keep;
      s_rlast[p]          = b.last;
      s_rvalid[p]         = v;
    end
  endtask

  task automatic clear_obs();
    out_ports.delete();
    starts.delete();
    n_out_beats = 0;
    n_trunc     = 0;
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      gap[p] = 0;
    end
    hs            = '0;
    prev_ready    = '0;
    prev_valid    = '0;
    in_frame      = 1'b0;
    prev_out_last = 1'b0;
    cur_port      = 0;
    exp_ptr       = 0;
    clear_obs();
  endtask

  // Called at the falling edge: all checks on the previous rising edge's results.
  task automatic monitor();
    int            w, pp;
    logic [NP-1:0] ev;
    beat_t         e;
    chk("ready_onehot", ($countones(s_rready) <= 1), 1'b1);
    chk("busy_vs_ready", o_busy, |s_rready);
    if (s_rready != '0 && prev_ready == '0) begin
      w  = rr_winner(prev_valid, exp_ptr);
      ev = '0;
      if (w >= 0) ev[w] = 1'b1;
      chk("rr_grant", s_rready, ev);
      if (w >= 0) begin
        exp_ptr = (w + 1) % NP;
        starts.push_back(w);
      end
    end
    if (prev_out_last) chk("idle_gap_after_last", m_rvalid, 1'b0);
    if (m_rvalid) begin
      pp = int'(m_rport);
      n_out_beats++;
      if (o_trunc_err) n_trunc++;
      if (in_frame) chk("no_interleave", m_rport, cur_port);
      chk("beat_expected", (exp_q[pp].size() != 0), 1'b1);
      if (exp_q[pp].size() != 0) begin
        e = exp_q[pp].pop_front();
        chk("out_data", m_rdata, e.data);
        chk("out_user", m_ruser, e.user);
        chk("out_keep", m_rkeep, e.keep);
        chk("out_last", m_rlast, e.last);
        chk("out_trunc", o_trunc_err, e.trunc);
      end
      in_frame = !m_rlast;
      cur_port = pp;
      if (m_rlast) out_ports.push_back(pp);
    end else begin
      chk("idle_outputs", {m_rdata, m_rkeep, m_rlast, o_trunc_err}, '0);
    end
    prev_out_last = m_rvalid && m_rlast;
    hs            = s_rvalid & s_rready;
    prev_ready    = s_rready;
    prev_valid    = s_rvalid;
  endtask

  // One clock: check at the falling edge, then update sources just after the rise.
  task automatic cycle();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) void'(src_q[p].pop_front());
      if (gap[p] > 0) gap[p]--;
      else if (rnd_gaps && $urandom_range(0, 7) == 0) gap[p] = int'($urandom_range(1, 3));
    end
    drive();
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drain(input int budget);
    int c = 0;
    while (!all_empty() && c < budget) begin
      cycle();
      c++;
    end
    chk("drain_timeout", (c < budget), 1'b1);
    repeat (3) cycle();
  endtask

  // Assert reset right now (called just after a rising edge); outputs must clear at once.
  task automatic do_reset();
    i_rst = 1'b1;
    clear_model();
    drive();
    #1;
    chk("rst_out_valid_last", {m_rvalid, m_rlast, o_trunc_err, o_busy}, '0);
    chk("rst_out_data_keep", {m_rdata, m_rkeep}, '0);
    chk("rst_out_user_port", {m_ruser, m_rport}, '0);
    chk("rst_ready", s_rready, '0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic wait_beats(input int n, input string name);
    int c = 0;
    while (n_out_beats < n && c < 50) begin
      cycle();
      c++;
    end
    chk(name, (n_out_beats >= n), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   exp_ord[4];
    int   exp_beats, exp_tr;
    int   p, n;

    vecs[0] = '{0, 4, 4, 0};
    vecs[1] = '{1, 1, 1, 0};
    vecs[2] = '{0, 12, 8, 1};
    vecs[3] = '{1, 8, 8, 0};
    vecs[4] = '{0, 9, 8, 1};
    vecs[5] = '{1, 7, 7, 0};
    vecs[6] = '{0, 16, 8, 1};
    exp_ord = '{0, 1, 0, 1};
    rnd_gaps = 1'b0;

    i_rst = 1'b1;
    clear_model();
    drive();
    repeat (2) @(posedge i_clk);
    #1;
    do_reset();

    // Single 4-beat frame on port 0: arbitration then 2-cycle latency.
    add_frame(0, 4, 64'h11, 64'hA5);
    drive();
    cycle();
    chk("t1_ready_after_arb", s_rready, 2'b01);
    chk("t1_no_out_yet", m_rvalid, 1'b0);
    cycle();
    chk("t1_first_valid", m_rvalid, 1'b1);
    chk("t1_first_data", m_rdata, 64'h11);
    chk("t1_first_port", m_rport, 1'b0);
    drain(100);
    chk("t1_beats", n_out_beats, 4);
    chk("t1_ready_low", s_rready, 2'b00);
    chk("t1_user_held", m_ruser, {16'd4, 64'hA5});

    // Both ports backlogged from reset: strict alternation.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      add_frame(0, 3, 64'h1000 + 64'(f) * 64'h100, 64'hB0);
      add_frame(1, 3, 64'h2000 + 64'(f) * 64'h100, 64'hB1);
    end
    drive();
    drain(200);
    chk("t2_frames", out_ports.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", out_ports[i], exp_ord[i]);
      chk("t2_grant_order", starts[i], exp_ord[i]);
    end

    // Port 1 alone: three single-beat frames.
    clear_obs();
    for (int f = 0; f < 3; f++) add_frame(1, 1, 64'h3000 + 64'(f), 64'hC1);
    drive();
    drain(100);
    chk("t3_beats", n_out_beats, 3);
    chk("t3_frames", out_ports.size(), 3);
    for (int i = 0; i < 3; i++) chk("t3_port", out_ports[i], 1);

    // Table of single frames around the truncation boundary.
    do_reset();
    foreach (vecs[i]) begin
      clear_obs();
      add_frame(vecs[i].port, vecs[i].nbeats, 64'h4000 + 64'(i) * 64'h1000, 64'(i));
      drive();
      drain(200);
      chk("tv_beats", n_out_beats, vecs[i].exp_beats);
      chk("tv_trunc", n_trunc, vecs[i].exp_trunc);
      chk("tv_frames", out_ports.size(), 1);
      chk("tv_port", out_ports[0], vecs[i].port);
    end

    // Truncated 12-beat frame with port 1 waiting behind it.
    do_reset();
    add_frame(0, 12, 64'h5000, 64'hD0);
    add_frame(1, 3, 64'h6000, 64'hD1);
    drive();
    drain(200);
    chk("t4_beats", n_out_beats, 11);
    chk("t4_trunc_once", n_trunc, 1);
    chk("t4_frames", out_ports.size(), 2);
    chk("t4_first", out_ports[0], 0);
    chk("t4_second", out_ports[1], 1);

    // Reset in the middle of an output frame.
    do_reset();
    add_frame(0, 5, 64'h7000, 64'hE0);
    drive();
    wait_beats(2, "t5_reach_beat2");
    chk("t5_pre_reset_valid", m_rvalid, 1'b1);
    do_reset();
    add_frame(1, 3, 64'h8000, 64'hE1);
    drive();
    drain(100);
    chk("t5_frames", out_ports.size(), 1);
    chk("t5_port1", out_ports[0], 1);
    chk("t5_grant_port1", starts[0], 1);

    // Granted port stalls for 5 cycles while port 1 requests.
    do_reset();
    add_frame(0, 6, 64'h9000, 64'hF0);
    add_frame(1, 2, 64'hA000, 64'hF1);
    drive();
    wait_beats(2, "t6_reach_beat2");
    gap[0] = 5;
    drive();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t6_grant_held", s_rready, 2'b01);
      chk("t6_no_out", m_rvalid, 1'b0);
    end
    drain(100);
    chk("t6_beats", n_out_beats, 8);
    chk("t6_frames", out_ports.size(), 2);
    chk("t6_first", out_ports[0], 0);
    chk("t6_second", out_ports[1], 1);

    // Randomized traffic with random valid gaps.
    do_reset();
    rnd_gaps  = 1'b1;
    exp_beats = 0;
    exp_tr    = 0;
    for (int f = 0; f < 40; f++) begin
      p = int'($urandom_range(0, NP - 1));
      n = int'($urandom_range(1, 12));
      exp_beats += (n > MB) ? MB : n;
      if (n > MB) exp_tr++;
      add_frame(p, n, {$urandom, $urandom}, {$urandom, $urandom});
    end
    drive();
    drain(8000);
    rnd_gaps = 1'b0;
    chk("rnd_beats", n_out_beats, exp_beats);
    chk("rnd_trunc", n_trunc, exp_tr);
    chk("rnd_frames", out_ports.size(), 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
